// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the instruction phase sequencer.
// Holds the FSM state encoding, select-code values and the legal-code check.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_P1,
    ST_P2,
    ST_P3,
    ST_P4,
    ST_P5,
    ST_P6,
    ST_ERR
  } state_e;

  localparam logic [3:0] SEL_NONE = 4'd0;
  localparam logic [3:0] SEL_ESP  = 4'd1;
  localparam logic [3:0] SEL_EBP  = 4'd2;
  localparam logic [3:0] SEL_IMM  = 4'd3;
  localparam logic [3:0] SEL_ESP2 = 4'd4;
  localparam logic [3:0] SEL_MAX  = 4'd4;

  localparam int PHASE_CNT = 6;

  // First operand must name a real register; second may be SEL_NONE.
  function automatic logic codes_legal(input logic [3:0] s1, input logic [3:0] s2);
    return (s1 >= SEL_ESP) && (s1 <= SEL_MAX) && (s2 <= SEL_MAX);
  endfunction

endpackage

// File: rtl/seq_retire_counter.sv
// Wrapping retired-instruction counter with synchronous active-low clear.
module seq_retire_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_clear_n,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_clear_n) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/phase_sequencer.sv
// Six-phase instruction sequencer: accepts one instruction in IDLE, walks the
// one-hot phase strobes, flags illegal select codes and counts retirements.
module phase_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int RETIRE_W = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [3:0]          sel1_in,
  input  logic [3:0]          sel2_in,
  input  logic                stall,
  output logic                clock_1,
  output logic                clock_2,
  output logic                clock_3,
  output logic                clock_4,
  output logic                clock_5,
  output logic                clock_6,
  output logic [3:0]          select_1,
  output logic [3:0]          select_2,
  output logic                done,
  output logic                err,
  output logic [RETIRE_W-1:0] retired
);

  state_e                 r_state;
  state_e                 w_next;
  logic [3:0]             r_select_1;
  logic [3:0]             r_select_2;
  logic [PHASE_CNT-1:0]   w_strobe;
  logic                   w_done;
  logic                   w_err;
  logic                   w_ready;
  logic                   w_accept;
  logic                   w_legal;

  assign w_accept = instr_valid && (r_state == ST_IDLE);
  assign w_legal  = codes_legal(sel1_in, sel2_in);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Illegal accepts consume the instruction but leave the selects untouched.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_select_1 <= SEL_NONE;
      r_select_2 <= SEL_NONE;
    end else if (w_accept && w_legal) begin
      r_select_1 <= sel1_in;
      r_select_2 <= sel2_in;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (instr_valid) w_next = w_legal ? ST_P1 : ST_ERR;
      ST_P1:   if (!stall) w_next = ST_P2;
      ST_P2:   if (!stall) w_next = ST_P3;
      ST_P3:   if (!stall) w_next = ST_P4;
      ST_P4:   if (!stall) w_next = (r_select_2 != SEL_NONE) ? ST_P5 : ST_P6;
      ST_P5:   if (!stall) w_next = ST_P6;
      ST_P6:   if (!stall) w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Strobes come from the state register only; done alone looks at stall.
  always_comb begin
    w_strobe = '0;
    w_done   = 1'b0;
    w_err    = 1'b0;
    w_ready  = 1'b0;
    case (r_state)
      ST_IDLE: w_ready = 1'b1;
      ST_P1:   w_strobe[0] = 1'b1;
      ST_P2:   w_strobe[1] = 1'b1;
      ST_P3:   w_strobe[2] = 1'b1;
      ST_P4:   w_strobe[3] = 1'b1;
      ST_P5:   w_strobe[4] = 1'b1;
      ST_P6: begin
        w_strobe[5] = 1'b1;
        w_done      = !stall;
      end
      ST_ERR:  w_err = 1'b1;
      default: w_ready = 1'b0;
    endcase
  end

  seq_retire_counter #(
    .W(RETIRE_W)
  ) u_retire (
    .i_clk    (clock),
    .i_clear_n(reset_n),
    .i_en     (w_done),
    .o_count  (retired)
  );

  assign clock_1     = w_strobe[0];
  assign clock_2     = w_strobe[1];
  assign clock_3     = w_strobe[2];
  assign clock_4     = w_strobe[3];
  assign clock_5     = w_strobe[4];
  assign clock_6     = w_strobe[5];
  assign done        = w_done;
  assign err         = w_err;
  assign instr_ready = w_ready;
  assign select_1    = r_select_1;
  assign select_2    = r_select_2;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: stimulus pushes per-cycle expected
// outputs, a negedge monitor pops and compares them against the DUT.
module tb_phase_sequencer;

  localparam int RW = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          stall = 1'b0;
  logic [3:0]    sel1_in = 4'd0;
  logic [3:0]    sel2_in = 4'd0;
  logic          instr_ready;
  logic          clock_1, clock_2, clock_3, clock_4, clock_5, clock_6;
  logic [3:0]    select_1, select_2;
  logic          done, err;
  logic [RW-1:0] retired;

  phase_sequencer #(.RETIRE_W(RW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .sel1_in    (sel1_in),
    .sel2_in    (sel2_in),
    .stall      (stall),
    .clock_1    (clock_1),
    .clock_2    (clock_2),
    .clock_3    (clock_3),
    .clock_4    (clock_4),
    .clock_5    (clock_5),
    .clock_6    (clock_6),
    .select_1   (select_1),
    .select_2   (select_2),
    .done       (done),
    .err        (err),
    .retired    (retired)
  );

  always #5 clock = ~clock;

  // ph: 0 = IDLE, 1..6 = phase, 7 = ERR
  typedef struct {
    int            ph;
    bit            dn;
    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [RW-1:0] ret;
    int            cyc;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc_n = 0;
  logic [3:0]    m_s1 = 4'd0;
  logic [3:0]    m_s2 = 4'd0;
  logic [RW-1:0] m_ret = '0;

  exp_t                e_mon;
  logic [5:0]          exp_str;
  logic [17+RW-1:0]    exp_vec;
  logic [17+RW-1:0]    act_vec;

  always @(negedge clock) begin
    if (q.size() > 0) begin
      e_mon   = q.pop_front();
      exp_str = (e_mon.ph >= 1 && e_mon.ph <= 6) ? 6'(1 << (e_mon.ph - 1)) : 6'd0;
      exp_vec = {exp_str, (e_mon.ph == 0), e_mon.dn, (e_mon.ph == 7),
                 e_mon.s1, e_mon.s2, e_mon.ret};
      act_vec = {clock_6, clock_5, clock_4, clock_3, clock_2, clock_1,
                 instr_ready, done, err, select_1, select_2, retired};
      checks++;
      if (act_vec !== exp_vec) begin
        failures++;
        $display("FAIL cycle%0d ph%0d: got strobes=%b rdy=%b done=%b err=%b s1=%0d s2=%0d ret=%0d, want strobes=%b rdy=%b done=%b err=%b s1=%0d s2=%0d ret=%0d",
                 e_mon.cyc, e_mon.ph,
                 {clock_6, clock_5, clock_4, clock_3, clock_2, clock_1},
                 instr_ready, done, err, select_1, select_2, retired,
                 exp_str, (e_mon.ph == 0), e_mon.dn, (e_mon.ph == 7),
                 e_mon.s1, e_mon.s2, e_mon.ret);
      end
    end
  end

  task automatic cyc(input int ph, input bit dn, input bit v, input logic [3:0] a,
                     input logic [3:0] b, input bit st, input bit rn);
    exp_t e;
    e.ph  = ph;
    e.dn  = dn;
    e.s1  = m_s1;
    e.s2  = m_s2;
    e.ret = m_ret;
    e.cyc = cyc_n;
    q.push_back(e);
    instr_valid = v;
    sel1_in     = a;
    sel2_in     = b;
    stall       = st;
    reset_n     = rn;
    @(posedge clock);
    #1;
    cyc_n++;
    if (dn) m_ret = m_ret + RW'(1);
  endtask

  task automatic idle();
    cyc(0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
  endtask

  // Legal instruction; junk drives an illegal valid instruction while busy.
  task automatic instr(input logic [3:0] a, input logic [3:0] b, input int st3,
                       input int st6, input bit junk, input bit stall_idle,
                       input bit abort);
    logic [3:0] ja;
    bit         fin;
    ja  = junk ? 4'd9 : 4'd0;
    fin = 1'b0;
    cyc(0, 1'b0, 1'b1, a, b, stall_idle, 1'b1);
    m_s1 = a;
    m_s2 = b;
    for (int p = 1; p <= 6; p++) begin
      if (!fin && !(p == 5 && b == 4'd0)) begin
        if (p == 3)
          for (int k = 0; k < st3; k++) cyc(3, 1'b0, junk, ja, ja, 1'b1, 1'b1);
        if (p == 6)
          for (int k = 0; k < st6; k++) cyc(6, 1'b0, junk, ja, ja, 1'b1, 1'b1);
        if (abort && p == 4) begin
          cyc(4, 1'b0, junk, ja, ja, 1'b0, 1'b0);
          m_s1  = 4'd0;
          m_s2  = 4'd0;
          m_ret = '0;
          fin   = 1'b1;
        end else begin
          cyc(p, (p == 6), junk, ja, ja, 1'b0, 1'b1);
        end
      end
    end
  endtask

  task automatic illegal(input logic [3:0] a, input logic [3:0] b, input bit stall_idle);
    cyc(0, 1'b0, 1'b1, a, b, stall_idle, 1'b1);
    cyc(7, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    cyc(0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    idle();
    instr(4'd1, 4'd2, 0, 0, 1'b0, 1'b0, 1'b0);
    instr(4'd4, 4'd0, 0, 0, 1'b0, 1'b0, 1'b0);
    instr(4'd2, 4'd3, 3, 2, 1'b1, 1'b1, 1'b0);
    illegal(4'd0, 4'd1, 1'b0);
    illegal(4'd1, 4'd7, 1'b1);
    instr(4'd3, 4'd4, 0, 0, 1'b0, 1'b0, 1'b0);
    instr(4'd1, 4'd1, 0, 0, 1'b0, 1'b0, 1'b1);
    idle();
    instr(4'd1, 4'd0, 0, 0, 1'b0, 1'b0, 1'b0);
    idle();
    idle();
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clock);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
